// File: rtl/serial_uart_bridge_if.sv
// Core-side handshake bundle for the serial UART bridge.
// master = core (data_memory serial port), slave = bridge.
interface serial_uart_bridge_if;
  logic [7:0] wr_data_in;
  logic       wren_in;
  logic       rden_in;
  logic [7:0] rd_data_out;
  logic       valid_out;
  logic       ready_out;

  modport master (
    output wr_data_in, wren_in, rden_in,
    input  rd_data_out, valid_out, ready_out
  );

  modport slave (
    input  wr_data_in, wren_in, rden_in,
    output rd_data_out, valid_out, ready_out
  );
endinterface

// File: rtl/serial_uart_bridge.sv
// Serial port to 8N1 UART bridge: TX FIFO + shifter,
// 2-flop synchronised RX deserialiser + RX FIFO.
module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_uart_bridge_if.slave  bus,
  input  logic                 uart_rxd_in,
  output logic                 uart_txd_out,
  output logic                 rx_overrun_out,
  output logic                 rx_frame_err_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  state_t        tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;
  logic          tx_empty, tx_full, tx_push;

  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  state_t        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_s1_q, rx_s2_q;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_wr;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) &&
                    (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign tx_push  = bus.wren_in && !tx_full;

  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) &&
                    (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign rx_pop   = bus.rden_in && !rx_empty;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);

  assign bus.ready_out   = !tx_full;
  assign bus.valid_out   = !rx_empty;
  assign bus.rd_data_out = rx_empty ? 8'h00
                         : rx_mem_q[rx_rp_q[AW-1:0]];
  assign uart_txd_out     = txd_q;
  assign rx_overrun_out   = ovr_q;
  assign rx_frame_err_out = ferr_q;

  // TX: FIFO pointers, frame sequencing, txd lags state by one cycle
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_rp_d  = tx_rp_q;
    tx_wp_d  = tx_push ? tx_wp_q + PW'(1) : tx_wp_q;
    txd_d    = 1'b1;
    unique case (tx_st_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_sh_d  = tx_mem_q[tx_rp_q[AW-1:0]];
          tx_rp_d  = tx_rp_q + PW'(1);
          tx_cnt_d = '0;
          tx_st_d  = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          tx_st_d  = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        txd_d = tx_sh_q[0];
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          tx_st_d  = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  // RX: mid-bit sampling deserialiser, FIFO pointers, sticky flags
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    ferr_d   = ferr_q;
    unique case (rx_st_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF) begin
          rx_cnt_d = '0;
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == LAST) begin
          rx_cnt_d = '0;
          rx_st_d  = S_IDLE;
          if (rx_s2_q) rx_push = 1'b1;
          else         ferr_d  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
    rx_wp_d = rx_wr  ? rx_wp_q + PW'(1) : rx_wp_q;
    rx_rp_d = rx_pop ? rx_rp_q + PW'(1) : rx_rp_q;
    ovr_d   = ovr_q | (rx_push && rx_full && !rx_pop);
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      txd_q    <= 1'b1;
      rx_st_q  <= S_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      txd_q    <= txd_d;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_s1_q  <= uart_rxd_in;
      rx_s2_q  <= rx_s1_q;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  // FIFO storage; contents need no reset, pointers guard them
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= bus.wr_data_in;
    if (rx_wr)   rx_mem_q[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end
endmodule

// File: tb/tb_serial_uart_bridge.sv
// Scoreboard bench for serial_uart_bridge
// (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_serial_uart_bridge;
  localparam int CPB = 4;
  localparam int PITCH = 10 * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;
  logic txd, ovr, ferr;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int         start_cyc[$];

  serial_uart_bridge_if bus ();

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock            (clk),
    .reset            (rst),
    .bus              (bus),
    .uart_rxd_in      (rxd),
    .uart_txd_out     (txd),
    .rx_overrun_out   (ovr),
    .rx_frame_err_out (ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      step(CPB);
    end
    rxd = stop;
    step(CPB);
    rxd = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (bus.valid_out !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while (tx_exp.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("tx_drain", tx_exp.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    tx_exp.delete();
    rx_exp.delete();
  endtask

  // TX monitor: decodes each frame on txd, compares with scoreboard
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    logic       stop;
    logic [7:0] e;
    bit         ab;
    prev = 1'b1;
    b    = '0;
    stop = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && prev === 1'b1 && txd === 1'b0) begin
        start_cyc.push_back(cyc);
        ab = 1'b0;
        for (int j = 1; j <= 1 + 9 * CPB && !ab; j++) begin
          @(negedge clk);
          if (rst !== 1'b0) ab = 1'b1;
          for (int i = 0; i < 8; i++)
            if (j == 1 + CPB * (i + 1)) b[i] = txd;
          if (j == 1 + 9 * CPB) stop = txd;
        end
        if (!ab) begin
          if (tx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got %0h expected none", b);
          end else begin
            e = tx_exp.pop_front();
            chk("tx_byte", b, e);
            chk("tx_stop", stop, 1);
          end
          prev = 1'b1;
        end else begin
          prev = txd;
        end
      end else begin
        prev = txd;
      end
    end
  end

  // RX monitor: every accepted pop is compared with scoreboard
  initial begin : rx_mon
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.rden_in === 1'b1 && bus.valid_out === 1'b1) begin
        if (rx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected none",
                   bus.rd_data_out);
        end else begin
          e = rx_exp.pop_front();
          chk("rx_byte", bus.rd_data_out, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.wr_data_in = 8'h00;
    bus.wren_in    = 1'b0;
    bus.rden_in    = 1'b0;
    step(1);
    do_reset();
    @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_ready", bus.ready_out, 1);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_rdata", bus.rd_data_out, 8'h00);
    chk("rst_ovr", ovr, 0);
    chk("rst_ferr", ferr, 0);

    // 1: single byte, latency and bit pattern
    step(1);
    tx_exp.push_back(8'hA5);
    bus.wr_data_in = 8'hA5;
    bus.wren_in    = 1'b1;
    step(1);
    bus.wren_in = 1'b0;
    @(negedge clk);
    chk("t1_ready", bus.ready_out, 1);
    chk("t1_txd_k", txd, 1);
    step(1);
    @(negedge clk);
    chk("t1_txd_k1", txd, 1);
    step(1);
    @(negedge clk);
    chk("t1_txd_k2", txd, 0);
    wait_tx_drain(60);
    step(3);

    // 2: overfill TX FIFO, check drop and back-to-back pitch
    start_cyc.delete();
    for (int i = 1; i <= 5; i++) tx_exp.push_back(8'(i));
    for (int i = 0; i < 6; i++) begin
      bus.wr_data_in = 8'(i + 1);
      bus.wren_in    = 1'b1;
      @(negedge clk);
      if (i == 4) chk("t2_ready_3q", bus.ready_out, 1);
      if (i == 5) chk("t2_ready_full", bus.ready_out, 0);
      step(1);
    end
    bus.wren_in = 1'b0;
    wait_tx_drain(400);
    chk("t2_nframes", start_cyc.size(), 5);
    for (int i = 1; i < start_cyc.size(); i++)
      chk("t2_pitch", start_cyc[i] - start_cyc[i-1], PITCH);
    step(8);

    // 3: receive one byte and pop it
    send_rx(8'h3C, 1'b1);
    wait_valid(20);
    chk("t3_valid", bus.valid_out, 1);
    chk("t3_rdata", bus.rd_data_out, 8'h3C);
    step(1);
    rx_exp.push_back(8'h3C);
    bus.rden_in = 1'b1;
    step(1);
    bus.rden_in = 1'b0;
    @(negedge clk);
    chk("t3_valid_after", bus.valid_out, 0);
    chk("t3_rdata_after", bus.rd_data_out, 8'h00);
    step(2);

    // 4: five frames into a 4-deep RX FIFO
    for (int i = 0; i < 4; i++) begin
      send_rx(8'(8'h10 + i), 1'b1);
      step(2);
    end
    step(20);
    chk("t4_ovr_at_full", ovr, 0);
    send_rx(8'h14, 1'b1);
    step(20);
    chk("t4_ovr", ovr, 1);
    for (int i = 0; i < 4; i++) rx_exp.push_back(8'(8'h10 + i));
    bus.rden_in = 1'b1;
    step(4);
    bus.rden_in = 1'b0;
    @(negedge clk);
    chk("t4_valid_after", bus.valid_out, 0);
    chk("t4_rdata_after", bus.rd_data_out, 8'h00);
    chk("t4_drained", rx_exp.size(), 0);
    step(1);

    // 5: glitch rejection, then framing error
    do_reset();
    rxd = 1'b0;
    step(1);
    rxd = 1'b1;
    step(20);
    chk("t5_glitch_valid", bus.valid_out, 0);
    chk("t5_glitch_ferr", ferr, 0);
    send_rx(8'h55, 1'b0);
    step(10);
    chk("t5_ferr_valid", bus.valid_out, 0);
    chk("t5_ferr", ferr, 1);
    chk("t5_ovr", ovr, 0);

    // 6: reset mid-frame on both paths
    for (int i = 0; i < 3; i++) begin
      bus.wr_data_in = (i == 0) ? 8'hC3 : (i == 1) ? 8'h81 : 8'h7E;
      bus.wren_in    = 1'b1;
      step(1);
    end
    bus.wren_in = 1'b0;
    rxd = 1'b0;
    step(8);
    rxd = 1'b1;
    step(4);
    rxd = 1'b0;
    step(4);
    rst = 1'b1;
    rxd = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_txd", txd, 1);
    chk("t6_ready", bus.ready_out, 1);
    chk("t6_valid", bus.valid_out, 0);
    chk("t6_rdata", bus.rd_data_out, 8'h00);
    chk("t6_ovr", ovr, 0);
    chk("t6_ferr", ferr, 0);
    step(120);
    @(negedge clk);
    chk("t6_txd_quiet", txd, 1);
    chk("t6_valid_quiet", bus.valid_out, 0);
    chk("end_tx_sb", tx_exp.size(), 0);
    chk("end_rx_sb", rx_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
